seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Time-multiplexing scheduler and arbiter for the 4-digit seven-segment output stage. It owns the digit-refresh timing and inserts an optional blanking gap between digits to suppress ghosting. It also shares the display between two requesters (A = video-text status register, B = debug/diagnostic source), granting ownership one whole frame at a time. Its outputs feed the display driver's digit-advance strobe, mode select and 8-bit value input.

## Interface
Parameters:
- PRESCALE, 50000: clock cycles each digit is driven (slot length); legal range ≥2.
- BLANK, 16: clock cycles of blanking after each slot; legal range ≥1; used only with the blanking feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A wants the display.
- data_a  in  8  value from A.
- mode_a  in  1  A's display mode (0 = dec, 1 = hex).
- req_b  in  1  requester B wants the display.
- data_b  in  8  value from B.
- mode_b  in  1  B's display mode.
- grant  out  2  one-hot owner: 01 = A, 10 = B, 00 = none.
- disp_data  out  8  value latched for the current frame.
- disp_mode  out  1  mode latched for the current frame.
- digit_tick  out  1  one-cycle pulse at the first cycle of every slot; advances the driver's digit counter.
- digit_idx  out  2  digit currently driven, 0..3.
- blank  out  1  1 = all cathode commons must be off.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- States: IDLE, SLOT, GAP. GAP exists only with SEG_SCHED_BLANK_EN.
- IDLE:
  - Outputs: blank=1, grant=00.
  - Arbitration runs every cycle. Any req moves the FSM to SLOT with digit_idx=0 on the next cycle.
- SLOT:
  - Drives digit_idx, with blank=0, for PRESCALE cycles.
  - Then goes to GAP, or straight to the next SLOT when blanking is compiled out.
- GAP: blank=1 for BLANK cycles, then the next SLOT.
- digit_idx increments 0→1→2→3 and wraps to 0 only at a frame boundary.
- A frame is 4 slots (plus 4 gaps when blanking is enabled).
- Arbitration:
  - Evaluated on the last cycle of a frame, and every cycle in IDLE.
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins (round-robin). The last-owner pointer resets to B, so A wins the first tie.
  - Neither high: the FSM goes to IDLE, grant becomes 00, and disp_data/disp_mode hold their values.
- data/mode of the winner are captured into disp_data/disp_mode on the same edge grant updates. They are held constant for the whole frame.
- Dropping req mid-frame has no effect until the frame boundary. The frame always completes.
- Back-to-back frames with an active requester run with no idle cycle between them.

## Timing
- Reset values: state=IDLE, grant=00, disp_data=00, disp_mode=0, digit_tick=0, digit_idx=0, blank=1, frame_done=0, last-owner=B.
- Reset asserted mid-frame forces these values immediately (asynchronous). Release resumes in IDLE.
- Latency:
  - From req sampled high in IDLE at edge N: at edge N+1, grant, disp_data and digit_idx=0 are valid and digit_tick=1.
- Frame length:
  - With blanking: 4·(PRESCALE+BLANK) cycles.
  - Without blanking: 4·PRESCALE cycles.
- digit_tick is high for exactly 1 cycle per slot, coincident with the new digit_idx.
- frame_done is high on the final GAP cycle, or the final SLOT cycle without blanking. It coincides with the arbitration decision.
- The slot/gap counter counts down from PRESCALE-1 and BLANK-1 to 0. Its width is $clog2(max(PRESCALE, BLANK)).

## Configuration
- SEG_SCHED_BLANK_EN defined:
  - GAP state and BLANK parameter are active.
  - blank=1 during gaps and IDLE.
- Not defined:
  - No GAP state; BLANK is ignored.
  - Slots are contiguous, and blank=1 only in IDLE.

## Structure
- Package seg_sched_pkg holds:
  - State enum (IDLE, SLOT, GAP).
  - Owner encodings OWN_A=2'b01, OWN_B=2'b10, OWN_NONE=2'b00.
  - Digit-count constant NDIG=4.
- One sub-module, seg_slot_timer: loadable down-counter with a zero flag, shared for slot and gap timing.

## Test plan
Directed scenarios use PRESCALE=4, BLANK=2 unless noted.
- Reset, no requests: blank=1, grant=00, digit_tick never pulses over 100 cycles.
- Single requester:
  - Stimulus: req_a=1, data_a=0x3C, mode_a=1.
  - Response: grant=01 one cycle later; digit_tick pulses every 6 cycles; digit_idx cycles 0,1,2,3; frame_done every 24 cycles; disp_data=0x3C, disp_mode=1.
- Contention: req_a and req_b both held high → grants alternate A,B,A,B on successive 24-cycle frames, with no IDLE cycle.
- Mid-frame change:
  - Stimulus: data_a changes and req_a drops at cycle 10 of a frame.
  - Response: disp_data unchanged until frame_done; then grant=00 and blank=1.
- Async reset asserted during the digit 2 slot: all outputs take reset values before the next clk edge; the FSM restarts from IDLE.
- Blanking compiled out (SEG_SCHED_BLANK_EN undefined): frame is 16 cycles, blank=0 throughout an active frame, digit_tick every 4 cycles.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// rtl/seg_sched_pkg.sv - shared types and constants for the seven-segment display scheduler
//
// Contents:
//   sched_state_e  scheduler FSM states (IDLE, SLOT, GAP)
//   OWN_*          one-hot display owner encodings
//   NDIG           number of multiplexed digits per frame
//   rr_pick        round-robin winner selection between requesters A and B

package seg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam int NDIG = 4;

    // On a tie the requester that did not own the previous frame wins.
    function automatic logic [1:0] rr_pick(input logic       req_a,
                                           input logic       req_b,
                                           input logic [1:0] last_owner);
        logic [1:0] win;
        if (req_a && req_b) begin
            win = (last_owner == OWN_A) ? OWN_B : OWN_A;
        end else if (req_a) begin
            win = OWN_A;
        end else if (req_b) begin
            win = OWN_B;
        end else begin
            win = OWN_NONE;
        end
        return win;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - loadable down-counter with zero flag for slot and gap timing
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset (count clears to 0)
//   load_i      load load_val_i on the next edge (takes priority over counting)
//   load_val_i  value to load
//   cnt_o       current count
//   zero_o      1 when the count has reached 0; the counter then holds

module seg_slot_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - digit refresh timing and frame-granular arbiter for a 4-digit display
//
// Optional feature macro: SEG_SCHED_BLANK_EN (inserts a BLANK-cycle gap after every slot).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_a/data_a/mode_a       requester A (status register)
//   req_b/data_b/mode_b       requester B (debug source)
//   grant                     one-hot owner of the current frame (00 = none)
//   disp_data, disp_mode      winner's value/mode, frozen for the whole frame
//   digit_tick                pulse on the first cycle of each slot
//   digit_idx                 digit currently driven
//   blank                     all digit commons off
//   frame_done                pulse on the last cycle of each frame

module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       mode_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    input  logic       mode_b,
    output logic [1:0] grant,
    output logic [7:0] disp_data,
    output logic       disp_mode,
    output logic       digit_tick,
    output logic [1:0] digit_idx,
    output logic       blank,
    output logic       frame_done
);

    localparam int CNT_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SLOT_LOAD = CW'(PRESCALE - 1);
`ifdef SEG_SCHED_BLANK_EN
    localparam logic [CW-1:0] GAP_LOAD  = CW'(BLANK - 1);
`endif

    sched_state_e state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   last_q, last_d;
    logic [7:0]   data_q, data_d;
    logic         mode_q, mode_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_zero;

    logic [1:0] winner;
    logic       last_digit;
    logic       arbitrate;

    seg_slot_timer #(.W(CW)) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    assign winner     = rr_pick(req_a, req_b, last_q);
    assign last_digit = (idx_q == 2'(NDIG - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        last_d    = last_q;
        data_d    = data_q;
        mode_d    = mode_q;
        tmr_load  = 1'b0;
        tmr_val   = SLOT_LOAD;
        arbitrate = 1'b0;

        case (state_q)
            ST_IDLE: arbitrate = 1'b1;
            ST_SLOT: begin
                if (tmr_zero) begin
`ifdef SEG_SCHED_BLANK_EN
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
`else
                    if (last_digit) begin
                        arbitrate = 1'b1;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        tmr_load = 1'b1;
                    end
`endif
                end
            end
            ST_GAP: begin
`ifdef SEG_SCHED_BLANK_EN
                if (tmr_zero) begin
                    if (last_digit) begin
                        arbitrate = 1'b1;
                    end else begin
                        state_d  = ST_SLOT;
                        idx_d    = idx_q + 2'd1;
                        tmr_load = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame boundary (or idle): a winner starts a new frame on the very
        // next cycle; otherwise fall back to idle but keep the last value.
        if (arbitrate) begin
            idx_d = 2'd0;
            if (winner != OWN_NONE) begin
                state_d  = ST_SLOT;
                tmr_load = 1'b1;
                tmr_val  = SLOT_LOAD;
                grant_d  = winner;
                last_d   = winner;
                data_d   = (winner == OWN_A) ? data_a : data_b;
                mode_d   = (winner == OWN_A) ? mode_a : mode_b;
            end else begin
                state_d = ST_IDLE;
                grant_d = OWN_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            grant_q <= OWN_NONE;
            last_q  <= OWN_B;
            data_q  <= 8'h00;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign grant      = grant_q;
    assign disp_data  = data_q;
    assign disp_mode  = mode_q;
    assign digit_idx  = idx_q;
    assign blank      = (state_q != ST_SLOT);
    // The counter sits at its load value only on the first cycle of a slot.
    assign digit_tick = (state_q == ST_SLOT) && (tmr_cnt == SLOT_LOAD);
`ifdef SEG_SCHED_BLANK_EN
    assign frame_done = (state_q == ST_GAP) && tmr_zero && last_digit;
`else
    assign frame_done = (state_q == ST_SLOT) && tmr_zero && last_digit;
`endif

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - self-checking bench for seg_display_scheduler

module tb_seg_display_scheduler;

    localparam int P = 4;
    localparam int B = 2;
`ifdef SEG_SCHED_BLANK_EN
    localparam int GAPC      = B;
    localparam int FRAME_LIT = 24;
`else
    localparam int GAPC      = 0;
    localparam int FRAME_LIT = 16;
`endif
    localparam int SLOTLEN = P + GAPC;
    localparam int FRAME   = 4 * SLOTLEN;

    logic       clk, rst;
    logic       req_a, mode_a, req_b, mode_b;
    logic [7:0] data_a, data_b;
    logic [1:0] grant, digit_idx;
    logic [7:0] disp_data;
    logic       disp_mode, digit_tick, blank, frame_done;

    int checks = 0;
    int errors = 0;

    seg_display_scheduler #(.PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .data_a     (data_a),
        .mode_a     (mode_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .mode_b     (mode_b),
        .grant      (grant),
        .disp_data  (disp_data),
        .disp_mode  (disp_mode),
        .digit_tick (digit_tick),
        .digit_idx  (digit_idx),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: a frame is FRAME cycles of time t; slot = t / SLOTLEN, the first
    // P cycles of each slot are lit, the rest blanked.
    bit         m_act;
    int         m_t;
    logic [1:0] m_own, m_last;
    logic [7:0] m_data;
    logic       m_mode;

    function automatic logic [1:0] pick(input logic a, input logic b, input logic [1:0] last);
        if (a && b) return (last == 2'b01) ? 2'b10 : 2'b01;
        if (a) return 2'b01;
        if (b) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            m_own  <= 2'b00;
            m_last <= 2'b10;
            m_data <= 8'h00;
            m_mode <= 1'b0;
        end else if (!m_act || m_t == FRAME - 1) begin
            m_t <= 0;
            if (pick(req_a, req_b, m_last) == 2'b00) begin
                m_act <= 1'b0;
                m_own <= 2'b00;
            end else begin
                m_act  <= 1'b1;
                m_own  <= pick(req_a, req_b, m_last);
                m_last <= pick(req_a, req_b, m_last);
                m_data <= (pick(req_a, req_b, m_last) == 2'b01) ? data_a : data_b;
                m_mode <= (pick(req_a, req_b, m_last) == 2'b01) ? mode_a : mode_b;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("m_grant", grant, m_own);
            chk("m_disp_data", disp_data, m_data);
            chk("m_disp_mode", disp_mode, m_mode);
            chk("m_blank", blank, (!m_act || (m_t % SLOTLEN) >= P) ? 1 : 0);
            chk("m_tick", digit_tick, (m_act && (m_t % SLOTLEN) == 0) ? 1 : 0);
            chk("m_idx", digit_idx, m_act ? m_t / SLOTLEN : 0);
            chk("m_frame_done", frame_done, (m_act && m_t == FRAME - 1) ? 1 : 0);
        end
    end

    // Called on the first cycle of a frame; returns at the frame_done cycle.
    task automatic run_frame(output int len, output int ticks, output int seq);
        len   = 1;
        ticks = digit_tick ? 1 : 0;
        seq   = digit_tick ? int'(digit_idx) : 0;
        while (!frame_done && len < 200) begin
            @(negedge clk);
            len++;
            if (digit_tick) begin
                ticks++;
                seq = seq * 4 + int'(digit_idx);
            end
        end
    endtask

    int n, tk, sq, gseq;

    initial begin
        rst = 1'b1;
        req_a = 0; req_b = 0; mode_a = 0; mode_b = 0;
        data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with no requests
        tk = 0;
        repeat (100) begin
            @(negedge clk);
            if (digit_tick) tk++;
        end
        chk("idle_ticks", tk, 0);
        chk("idle_blank", blank, 1);
        chk("idle_grant", grant, 0);

        // Single requester A
        req_a = 1; data_a = 8'h3C; mode_a = 1;
        @(negedge clk);
        chk("a_grant", grant, 1);
        chk("a_data", disp_data, 8'h3C);
        chk("a_mode", disp_mode, 1);
        chk("a_tick", digit_tick, 1);
        chk("a_idx", digit_idx, 0);
        run_frame(n, tk, sq);
        chk("a_frame_len", n, FRAME_LIT);
        chk("a_ticks", tk, 4);
        chk("a_idx_seq", sq, 27);

        // Contention: A owned last, so B, A, B, A
        req_b = 1; data_b = 8'hA5; mode_b = 0;
        gseq = 0;
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            gseq = gseq * 4 + int'(grant);
            run_frame(n, tk, sq);
            chk("rr_frame_len", n, FRAME_LIT);
        end
        chk("rr_seq", gseq, 153);

        // Mid-frame change of A's data and drop of req_a
        req_b = 0;
        @(negedge clk);
        chk("mid_grant", grant, 1);
        repeat (10) @(negedge clk);
        data_a = 8'h77; req_a = 0;
        run_frame(n, tk, sq);
        chk("mid_hold_data", disp_data, 8'h3C);
        @(negedge clk);
        chk("mid_end_grant", grant, 0);
        chk("mid_end_blank", blank, 1);
        chk("mid_end_data", disp_data, 8'h3C);

        // Asynchronous reset during the digit 2 slot
        req_a = 1; data_a = 8'h5A; mode_a = 0;
        n = 0;
        while (!(digit_idx == 2 && !blank) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_d2", (digit_idx == 2 && !blank) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_data", disp_data, 0);
        chk("rst_mode", disp_mode, 0);
        chk("rst_tick", digit_tick, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_blank", blank, 1);
        chk("rst_fd", frame_done, 0);
        req_a = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", grant, 0);
        chk("post_rst_blank", blank, 1);

        // First frame after reset: B alone wins
        req_b = 1; data_b = 8'hC3; mode_b = 1;
        @(negedge clk);
        chk("b_grant", grant, 2);
        chk("b_data", disp_data, 8'hC3);
        req_b = 0;
        run_frame(n, tk, sq);
        chk("b_frame_len", n, FRAME_LIT);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
